// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group
// is resolved per stage, with carry and unconsumed operand bits skewed forward.

module cla_group #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             ci,
   output logic [BLOCK-1:0] s,
   output logic             co,
   output logic             cmsb
);
   logic [BLOCK-1:0] g, p;
   logic [BLOCK:0]   c;
   logic             term;

   assign g = a & b;
   assign p = a | b;

   // Every carry is a flat sum of products of g/p and ci: no ripple inside the group.
   always_comb begin
      c    = '0;
      term = 1'b0;
      c[0] = ci;
      for (int i = 0; i < BLOCK; i++) begin
         term = ci;
         for (int j = 0; j <= i; j++) term = term & p[j];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            c[i+1] = c[i+1] | term;
         end
      end
   end

   assign s    = a ^ b ^ c[BLOCK-1:0];
   assign co   = c[BLOCK];
   assign cmsb = c[BLOCK-1];
endmodule

module pipelined_cla_adder #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4,
   parameter int NSTG  = WIDTH / BLOCK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   logic                        adv;
   logic [WIDTH-1:0]            beff;
   logic                        c0;

   logic [NSTG-1:0]             vld_pipe;
   logic [NSTG-1:0]             cy_q;
   logic [NSTG-1:0][WIDTH-1:0]  a_q, b_q, s_q;
   logic                        cmsb_q;

   logic [NSTG-1:0]             stg_v, stg_c;
   logic [NSTG-1:0][WIDTH-1:0]  stg_a, stg_b, stg_s, nxt_s;
   logic [NSTG-1:0][BLOCK-1:0]  grp_s;
   logic [NSTG-1:0]             grp_co, grp_cm;
   logic                        unused_bits;

   // Single global stall: the whole pipe moves or the whole pipe holds.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   assign beff = sub ? ~b : b;
   assign c0   = sub | cin;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      if (k == 0) begin : g_head
         assign stg_v[0] = in_valid;
         assign stg_a[0] = a;
         assign stg_b[0] = beff;
         assign stg_c[0] = c0;
         assign stg_s[0] = '0;
      end else begin : g_body
         assign stg_v[k] = vld_pipe[k-1];
         assign stg_a[k] = a_q[k-1];
         assign stg_b[k] = b_q[k-1];
         assign stg_c[k] = cy_q[k-1];
         assign stg_s[k] = s_q[k-1];
      end

      cla_group #(.BLOCK(BLOCK)) u_grp (
         .a    (stg_a[k][k*BLOCK +: BLOCK]),
         .b    (stg_b[k][k*BLOCK +: BLOCK]),
         .ci   (stg_c[k]),
         .s    (grp_s[k]),
         .co   (grp_co[k]),
         .cmsb (grp_cm[k])
      );
   end

   always_comb begin
      nxt_s = stg_s;
      for (int k = 0; k < NSTG; k++) nxt_s[k][k*BLOCK +: BLOCK] = grp_s[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         cy_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= '0;
         cmsb_q   <= 1'b0;
      end else if (adv) begin
         vld_pipe <= stg_v;
         cy_q     <= grp_co;
         a_q      <= stg_a;
         b_q      <= stg_b;
         s_q      <= nxt_s;
         cmsb_q   <= grp_cm[NSTG-1];
      end
   end

   assign out_valid = vld_pipe[NSTG-1];
   assign sum       = s_q[NSTG-1];
   assign cout      = cy_q[NSTG-1];
   assign ovf       = cmsb_q ^ cy_q[NSTG-1];

   // Last-stage skew copies and non-final MSB carries have no consumer.
   assign unused_bits = ^{a_q[NSTG-1], b_q[NSTG-1], grp_cm};
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Randomised + directed bench driving 16/4, 32/8 and 8/8 instances from shared
// stimulus, each scored against an arithmetic reference model.

module tb_pipelined_cla_adder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0;
   logic [63:0] a_in = '0, b_in = '0;
   logic [2:0]  ir, ov, co, of;
   logic [15:0] s0;
   logic [31:0] s1;
   logic [7:0]  s2;
   logic [63:0] sm [3];

   localparam int WD [3] = '{16, 32, 8};
   localparam int NS [3] = '{4, 4, 1};

   always #5 clk = ~clk;

   pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) u_d16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin), .sub(sub),
      .out_valid(ov[0]), .out_ready(out_ready), .sum(s0), .cout(co[0]), .ovf(of[0]));
   pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) u_d32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin), .sub(sub),
      .out_valid(ov[1]), .out_ready(out_ready), .sum(s1), .cout(co[1]), .ovf(of[1]));
   pipelined_cla_adder #(.WIDTH(8), .BLOCK(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
      .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin), .sub(sub),
      .out_valid(ov[2]), .out_ready(out_ready), .sum(s2), .cout(co[2]), .ovf(of[2]));

   always_comb begin
      sm[0] = {48'b0, s0};
      sm[1] = {32'b0, s1};
      sm[2] = {56'b0, s2};
   end

   typedef struct { logic [63:0] s; logic c; logic o; int t; } exp_t;
   typedef struct { logic [15:0] s; logic c; logic o; } log_t;

   exp_t        exp_q [3][$];
   log_t        log_q [$];
   exp_t        e;
   int          n_chk = 0, n_fail = 0, cyc = 0;
   bit          lat_on = 0, log_on = 0, rnd_done = 0;
   logic [63:0] prev_s [3];
   logic [2:0]  prev_c, prev_o, stalled = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: plain wide arithmetic, signed overflow from operand/result signs.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic ci, input logic sb);
      exp_t        r;
      logic [63:0] mask, ae, be;
      logic [64:0] full;
      mask   = (64'd1 << w) - 64'd1;
      ae     = a & mask;
      be     = (sb ? ~b : b) & mask;
      full   = {1'b0, ae} + {1'b0, be} + 65'(sb ? 1'b1 : ci);
      r.s    = full[63:0] & mask;
      r.c    = full[w];
      r.o    = (ae[w-1] == be[w-1]) && (r.s[w-1] != ae[w-1]);
      r.t    = 0;
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (stalled[i]) begin
               chk("hold_sum", sm[i], prev_s[i]);
               chk("hold_valid", 64'(ov[i]), 64'd1);
               chk("hold_flags", 64'({co[i], of[i]}), 64'({prev_c[i], prev_o[i]}));
            end
            if (ov[i] && !out_ready) chk("in_ready_stall", 64'(ir[i]), 64'd0);
            if (ov[i] && out_ready) begin
               if (exp_q[i].size() == 0) chk("unexpected_out", 64'(ov[i]), 64'd0);
               else begin
                  e = exp_q[i].pop_front();
                  chk("sum", sm[i], e.s);
                  chk("cout", 64'(co[i]), 64'(e.c));
                  chk("ovf", 64'(of[i]), 64'(e.o));
                  if (lat_on) chk("latency", 64'(cyc - e.t), 64'(NS[i]));
                  if (i == 0 && log_on) log_q.push_back('{s0, co[0], of[0]});
               end
            end
            if (in_valid && ir[i]) begin
               e   = model(WD[i], a_in, b_in, cin, sub);
               e.t = cyc;
               exp_q[i].push_back(e);
            end
            stalled[i] = ov[i] && !out_ready;
            prev_s[i]  = sm[i];
            prev_c[i]  = co[i];
            prev_o[i]  = of[i];
         end
      end else stalled = '0;
   end

   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb);
      int n;
      a_in = a; b_in = b; cin = ci; sub = sb; in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (ir[0]) break;
         if (++n > 50) begin
            chk("send_timeout", 64'(ir[0]), 64'd1);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [15:0] t_s [16] = '{16'h1235, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000, 16'h0080,
                             16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606,
                             16'h0707, 16'h0808, 16'h0000};
   logic        t_c [16] = '{0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
   logic        t_o [16] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

   initial begin
      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            chk("rst_valid", 64'(ov[i]), 64'd0);
            chk("rst_sum", sm[i], 64'd0);
         end
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk("ready_after_rst", 64'(ir[i]), 64'd1);
      @(posedge clk); #1;

      lat_on = 1; log_on = 1;
      send(64'h1234, 64'h0001, 1'b0, 1'b0);
      send('1, 64'h0, 1'b1, 1'b0);
      send(64'h7FFF, 64'h0001, 1'b0, 1'b0);
      send(64'h0005, 64'h0007, 1'b1, 1'b1);
      send(64'h8000, 64'h0001, 1'b0, 1'b1);
      send(64'h7FFF_FFFF, 64'h0001, 1'b0, 1'b0);
      send(64'h007F, 64'h0001, 1'b0, 1'b0);
      idle(8);
      for (int i = 1; i <= 8; i++) send(64'(i), 64'(32'h0100 * i), 1'b0, 1'b0);
      idle(8);
      log_on = 0; lat_on = 0;

      // Mid-stream backpressure window of five cycles.
      fork
         begin
            repeat (3) @(posedge clk);
            #2 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #2 out_ready = 1'b1;
         end
      join_none
      for (int i = 0; i < 6; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      idle(12);

      fork
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join_none
      for (int i = 0; i < 120; i++) begin
         logic [63:0] ra, rb;
         case ($urandom_range(0, 3))
            0:       ra = '1;
            1:       ra = '0;
            default: ra = {$urandom, $urandom};
         endcase
         rb = ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom, $urandom};
         if ($urandom_range(0, 4) == 0) idle(1);
         else send(ra, rb, 1'($urandom), 1'($urandom));
      end
      rnd_done = 1;
      idle(16);

      // Reset with three operations in flight.
      send(64'h1111, 64'h2222, 1'b0, 1'b0);
      send(64'h3333, 64'h4444, 1'b1, 1'b0);
      send(64'h5555, 64'h6666, 1'b0, 1'b1);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) exp_q[i].delete();
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("async_rst_valid", 64'(ov[i]), 64'd0);
         chk("async_rst_sum", sm[i], 64'd0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      idle(6);
      log_on = 1; lat_on = 1;
      send(64'h0F0F, 64'hF0F0, 1'b1, 1'b0);
      idle(8);

      chk("log_count", 64'(log_q.size()), 64'd16);
      for (int i = 0; i < 16 && i < log_q.size(); i++) begin
         chk("dir_sum", 64'(log_q[i].s), 64'(t_s[i]));
         chk("dir_cout", 64'(log_q[i].c), 64'(t_c[i]));
         chk("dir_ovf", 64'(log_q[i].o), 64'(t_o[i]));
      end
      for (int i = 0; i < 3; i++) chk("drained", 64'(exp_q[i].size()), 64'd0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Operand is split into BLOCK-bit lookahead groups. Each pipeline stage resolves one group and registers its carry-out for the next stage.
- Accepts one operation per cycle under a valid/ready handshake with full backpressure.
- Sits in the datapath wherever wide (16/32/64-bit) add/sub is needed at clock rates a single-cycle ripple or flat CLA cannot meet.

Parameters:
- WIDTH, 16, operand/sum width in bits. Must be a multiple of BLOCK and >= BLOCK.
- BLOCK, 4, bits per lookahead group. Equals bits resolved per pipeline stage.
- NSTG, WIDTH/BLOCK, derived; number of pipeline stages = latency in cycles. Not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/controls valid this cycle
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A-B (A + ~B + 1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB. For sub: 1 = no borrow (A >= B unsigned).
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
Reset:
- rst_n low asynchronously clears all stage valid bits, out_valid, sum, cout and ovf to 0.
- All data registers clear to 0.
- in_ready returns 1 on the first cycle after rst_n deasserts.
- Reset mid-operation discards every in-flight operation; no partial result is ever presented.

Operand conditioning at accept:
- beff = sub ? ~b : b
- c0 = sub ? 1 : cin
- Per bit: G = a & beff, P = a | beff.
- Group carry-out: Cout = G[n] | (P[n] & C[n-1]) expanded across the group (lookahead, not ripple, within a group).
- Sum bit = a ^ beff ^ carry-in of that bit.

Pipeline:
- Stage k (k = 0..NSTG-1) computes sum bits [k*BLOCK +: BLOCK] from the registered carry of stage k-1 (stage 0 uses c0).
- Stage k registers: its group carry, the sum bits produced so far, the unconsumed upper operand bits (skew registers), and the carry into the MSB (last stage only, for ovf).
- Each stage carries its own valid bit.

Handshake:
- Global advance enable: adv = ~out_valid | out_ready.
- in_ready = adv, purely combinational from out_valid/out_ready; no combinational path from in_valid.
- Transfer at input when in_valid & in_ready. Transfer at output when out_valid & out_ready.
- When adv=1, every stage shifts one step. An empty (invalid) slot shifts in when in_valid=0. Bubbles are preserved; no compaction.
- When adv=0, all stage registers hold, and sum/cout/ovf hold stable while out_valid=1.
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+NSTG-1, assuming no stalls. Every stall cycle adds one.
- Throughput: 1 op/cycle with out_ready held high.
- Simultaneous accept and output in the same cycle is legal and required.
- Results leave in acceptance order.

Arithmetic:
- sum = (a + beff + c0) mod 2^WIDTH.
- cout = bit WIDTH of the full sum.
- No saturation.

Test Plan:
Unless noted: WIDTH=16, BLOCK=4, out_ready=1.
1. Reset and latency:
   - Hold rst_n=0 for 3 cycles: out_valid=0, sum=0.
   - Release, then a=0x1234, b=0x0001, cin=0, sub=0 → after 4 cycles sum=0x1235, cout=0, ovf=0.
2. Full carry chain across all groups:
   - a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0.
   - a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
3. Subtract:
   - a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0 (borrow), ovf=0.
   - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
4. Back-to-back throughput: 8 consecutive ops a=i, b=0x0100*i (i=1..8), in_valid held 1 → 8 results on 8 consecutive cycles in order, first result 4 cycles after first accept.
5. Backpressure:
   - Stream 6 ops, drop out_ready for 5 cycles mid-stream → in_ready=0 during the stall.
   - sum/cout/ovf are stable while stalled; no result lost or duplicated; order preserved.
6. Reset mid-flight:
   - Assert rst_n=0 for 1 cycle while 3 ops are in flight → out_valid=0 immediately (asynchronous), no stale result afterwards.
   - Next op a=0x0F0F, b=0xF0F0, cin=1 → sum=0x0000, cout=1.
   - Repeat scenarios 2 and 4 with WIDTH=32, BLOCK=8 (latency 4) and WIDTH=8, BLOCK=8 (latency 1).
